// File: rtl/grid_io_param_tile_if.sv
// Pad-side bus of the parametrised I/O grid tile.
// master = fabric/pad environment, slave = the tile.
interface grid_io_param_tile_if #(
  parameter int NUM_IO = 9
) ();
  logic [NUM_IO-1:0] io_outpad;
  logic [NUM_IO-1:0] io_inpad;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT;
  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR;

  modport master (
    output io_outpad,
    output gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
    input  io_inpad,
    input  gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
    input  gfpga_pad_EMBEDDED_IO_HD_SOC_DIR
  );

  modport slave (
    input  io_outpad,
    input  gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
    output io_inpad,
    output gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
    output gfpga_pad_EMBEDDED_IO_HD_SOC_DIR
  );
endinterface

// File: rtl/grid_io_param_tile.sv
// Parametrised I/O grid tile: NUM_IO subtiles on one config chain,
// with a shadow config committed by cfg_load and per-pad inversion.
module grid_io_param_tile #(
  parameter int NUM_IO        = 9,
  parameter int CFG_BITS      = 3,
  parameter int ALLOW_PARTIAL = 0
) (
  input  logic prog_clk,
  input  logic pReset,
  input  logic IO_ISOL_N,
  input  logic ccff_head,
  input  logic ccff_shift_en,
  input  logic cfg_load,
  output logic ccff_tail,
  output logic cfg_done,
  output logic cfg_err,
  grid_io_param_tile_if.slave pads
);

  localparam int L  = NUM_IO * CFG_BITS;
  localparam int CW = $clog2(L + 1);
  localparam logic AP = (ALLOW_PARTIAL != 0);

  logic [L-1:0]  ch_q, ch_d;
  logic [L-1:0]  act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          load_ok;

  assign cfg_done  = (cnt_q == CW'(L));
  assign cfg_err   = err_q;
  assign ccff_tail = ch_q[L-1];
  assign load_ok   = cfg_load & (cfg_done | AP);

  always_comb begin
    ch_d  = ch_q;
    act_d = act_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (ccff_shift_en) begin
      for (int i = L - 1; i > 0; i--) ch_d[i] = ch_q[i-1];
      ch_d[0] = ccff_head;
      if (!cfg_done) cnt_d = cnt_q + CW'(1);
    end
    // commit sees the pre-shift chain; count restarts from this cycle's shift
    if (cfg_load) begin
      if (load_ok) begin
        act_d = ch_q;
        cnt_d = ccff_shift_en ? CW'(1) : CW'(0);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      ch_q  <= '0;
      act_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ch_q  <= ch_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  for (genvar k = 0; k < NUM_IO; k++) begin : g_pad
    logic dir_k, inv_in_k, inv_out_k;
    logic en_out, en_in;

    assign dir_k = act_q[k*CFG_BITS];

    if (CFG_BITS > 1) begin : g_ii
      assign inv_in_k = act_q[k*CFG_BITS+1];
    end else begin : g_ni
      assign inv_in_k = 1'b0;
    end

    if (CFG_BITS > 2) begin : g_io
      assign inv_out_k = act_q[k*CFG_BITS+2];
    end else begin : g_no
      assign inv_out_k = 1'b0;
    end

    assign en_out = IO_ISOL_N & dir_k;
    assign en_in  = IO_ISOL_N & ~dir_k;

    assign pads.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k] = en_out;
    assign pads.gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k] =
      en_out & (pads.io_outpad[k] ^ inv_out_k);
    assign pads.io_inpad[k] =
      en_in & (pads.gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k] ^ inv_in_k);
  end

endmodule

// File: tb/tb_grid_io_param_tile.sv
// Self-checking bench for grid_io_param_tile (NUM_IO=4, CFG_BITS=3),
// strict instance plus an ALLOW_PARTIAL=1 instance on shared stimulus.
module tb_grid_io_param_tile;

  localparam int N = 4;
  localparam int L = 12;

  logic clk = 1'b0;
  logic rst, isol, head, sh, ld;
  logic [N-1:0] outpad, socin;

  logic tail_a, done_a, err_a;
  logic tail_b, done_b, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  grid_io_param_tile_if #(.NUM_IO(N)) pa ();
  grid_io_param_tile_if #(.NUM_IO(N)) pb ();

  assign pa.io_outpad = outpad;
  assign pb.io_outpad = outpad;
  assign pa.gfpga_pad_EMBEDDED_IO_HD_SOC_IN = socin;
  assign pb.gfpga_pad_EMBEDDED_IO_HD_SOC_IN = socin;

  grid_io_param_tile #(.NUM_IO(N), .CFG_BITS(3), .ALLOW_PARTIAL(0)) dut (
    .prog_clk(clk), .pReset(rst), .IO_ISOL_N(isol),
    .ccff_head(head), .ccff_shift_en(sh), .cfg_load(ld),
    .ccff_tail(tail_a), .cfg_done(done_a), .cfg_err(err_a),
    .pads(pa.slave)
  );

  grid_io_param_tile #(.NUM_IO(N), .CFG_BITS(3), .ALLOW_PARTIAL(1)) dut_p (
    .prog_clk(clk), .pReset(rst), .IO_ISOL_N(isol),
    .ccff_head(head), .ccff_shift_en(sh), .cfg_load(ld),
    .ccff_tail(tail_b), .cfg_done(done_b), .cfg_err(err_b),
    .pads(pb.slave)
  );

  typedef struct {
    logic         isol;
    logic [N-1:0] outpad;
    logic [N-1:0] socin;
    logic [N-1:0] e_dir;
    logic [N-1:0] e_out;
    logic [N-1:0] e_in;
  } vec_t;

  vec_t vt[6];
  logic sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    head = b;
    sh   = 1'b1;
    clk1();
    sh   = 1'b0;
  endtask

  task automatic shift_vec(input logic [L-1:0] v);
    for (int i = L - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic pulse_load();
    ld = 1'b1;
    clk1();
    ld = 1'b0;
  endtask

  initial begin
    logic [19:0] pat;
    logic        exp_b;

    // after config {001,000,101,010}: dir=1010 inv_in=0001 inv_out=0010
    vt[0] = '{1'b1, 4'b1111, 4'b0000, 4'b1010, 4'b1000, 4'b0001};
    vt[1] = '{1'b1, 4'b0000, 4'b0000, 4'b1010, 4'b0010, 4'b0001};
    vt[2] = '{1'b1, 4'b1010, 4'b0101, 4'b1010, 4'b1000, 4'b0100};
    vt[3] = '{1'b1, 4'b0101, 4'b1111, 4'b1010, 4'b0010, 4'b0100};
    vt[4] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vt[5] = '{1'b1, 4'b1111, 4'b1111, 4'b1010, 4'b1000, 4'b0100};

    rst = 1'b1; isol = 1'b1; head = 1'b0; sh = 1'b0; ld = 1'b0;
    outpad = 4'b1111; socin = 4'b1010;
    clk1();
    clk1();
    rst = 1'b0;
    #1;
    chk("rst_inpad", pa.io_inpad, 4'b1010);
    chk("rst_dir", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, 4'b0000);
    chk("rst_out", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_OUT, 4'b0000);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_tail", tail_a, 0);

    // full configuration; pads must not move until the load
    shift_vec(12'b001_000_101_010);
    chk("cfg_done_full", done_a, 1);
    chk("dir_before_load", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, 4'b0000);
    pulse_load();
    chk("done_after_load", done_a, 0);
    chk("err_after_load", err_a, 0);

    foreach (vt[i]) begin
      isol = vt[i].isol; outpad = vt[i].outpad; socin = vt[i].socin;
      #1;
      chk($sformatf("vec%0d_dir", i), pa.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, vt[i].e_dir);
      chk($sformatf("vec%0d_out", i), pa.gfpga_pad_EMBEDDED_IO_HD_SOC_OUT, vt[i].e_out);
      chk($sformatf("vec%0d_in", i), pa.io_inpad, vt[i].e_in);
    end

    // partial shift then load: strict rejects, partial accepts
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    pulse_load();
    chk("part_err", err_a, 1);
    chk("part_dir_hold", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, 4'b1010);
    chk("part_out_hold", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_OUT, 4'b1000);
    chk("ap_err", err_b, 0);
    chk("ap_dir", pb.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, 4'b0111);
    for (int i = 0; i < 6; i++) shift_bit(1'b0);
    chk("part_done_6", done_a, 0);
    shift_bit(1'b0);
    chk("part_done_7", done_a, 1);
    chk("ap_done_7", done_b, 0);
    chk("err_sticky", err_a, 1);

    // load and shift together: pre-shift chain 111110000000 committed, cnt=1
    head = 1'b1; sh = 1'b1; ld = 1'b1;
    clk1();
    sh = 1'b0; ld = 1'b0;
    chk("ls_dir", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, 4'b1000);
    chk("ls_out", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_OUT, 4'b0000);
    chk("ls_in", pa.io_inpad, 4'b0011);
    chk("ls_done", done_a, 0);
    for (int i = 0; i < 10; i++) shift_bit(1'b0);
    chk("ls_done_11", done_a, 0);
    shift_bit(1'b0);
    chk("ls_done_12", done_a, 1);

    // reset wins over a concurrent shift and load
    head = 1'b1; sh = 1'b1; ld = 1'b1; rst = 1'b1;
    clk1();
    sh = 1'b0; ld = 1'b0; rst = 1'b0;
    chk("mrst_dir", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, 4'b0000);
    chk("mrst_out", pa.gfpga_pad_EMBEDDED_IO_HD_SOC_OUT, 4'b0000);
    chk("mrst_in", pa.io_inpad, socin);
    chk("mrst_done", done_a, 0);
    chk("mrst_err", err_a, 0);
    chk("mrst_tail", tail_a, 0);

    // tail scoreboard over 20 shifts from a cleared chain
    pat = 20'b1011_0011_1000_1101_0110;
    for (int i = 0; i < L - 1; i++) sb_q.push_back(1'b0);
    for (int i = 0; i < 20; i++) begin
      sb_q.push_back(pat[i]);
      shift_bit(pat[i]);
      exp_b = sb_q.pop_front();
      chk($sformatf("tail%0d", i), tail_a, exp_b);
    end
    chk("sat_done", done_a, 1);
    pulse_load();
    chk("sat_load_err", err_a, 0);
    chk("sat_load_done", done_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
